pipelined_adder: RTL and testbench

Parametrised N-bit adder/subtractor. It splits a WIDTH-bit carry chain into WIDTH/CHUNK registered slices, so each slice adds CHUNK bits per cycle.
It generalises the single-bit half adder to wide operands with carry-in, a per-transaction subtract mode, signed overflow and a valid/ready stream handshake.
It sits in the arithmetic datapath library as the reusable adder for later ALU and accumulator blocks.

---
 rtl/pipelined_adder.sv | 100 ++++++++++
 tb/tb_pipelined_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor with a valid/ready stream interface.
// Each stage adds one CHUNK-bit slice and passes its carry to the next stage.
module pipelined_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned CW     = CHUNK + 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1 and a multiple of CHUNK");
  end

  // Per-stage state: x holds finished sum slices below and A slices above,
  // y holds the effective B operand, cy the carry out of the stage's slice.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  x_q [STAGES];
  logic [WIDTH-1:0]  y_q [STAGES];
  logic              ovf_q;

  logic [WIDTH-1:0]  x_in  [STAGES];
  logic [WIDTH-1:0]  y_in  [STAGES];
  logic [WIDTH-1:0]  x_d   [STAGES];
  logic [CW-1:0]     sum_d [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic              advance;

  assign advance  = !vld_q[LAST] || out_ready;
  assign in_ready = advance;

  // Slice adders; stage 0 takes the prepared operands straight from the inputs.
  always_comb begin
    x_in[0] = A;
    y_in[0] = Sub ? ~B : B;
    c_in[0] = Sub | Cin;
    for (int k = 1; k < STAGES; k++) begin
      x_in[k] = x_q[k-1];
      y_in[k] = y_q[k-1];
      c_in[k] = cy_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k] = CW'(x_in[k][k*CHUNK +: CHUNK]) + CW'(y_in[k][k*CHUNK +: CHUNK])
               + CW'(c_in[k]);
      x_d[k] = x_in[k];
      x_d[k][k*CHUNK +: CHUNK] = sum_d[k][CHUNK-1:0];
      c_d[k] = sum_d[k][CHUNK];
    end
    // Carry into the MSB recovered from the MSB operand and sum bits.
    ovf_d = x_in[LAST][WIDTH-1] ^ y_in[LAST][WIDTH-1] ^ x_d[LAST][WIDTH-1] ^ c_d[LAST];
  end

  // Whole pipeline moves together; a stalled output freezes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_in[k];
      end
      cy_q  <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = vld_q[LAST];
  assign S         = x_q[LAST];
  assign Cout      = cy_q[LAST];
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: directed 8-bit/4-bit-chunk vectors plus an exhaustive
// 4-bit/1-bit-chunk sweep under random output backpressure.
module tb_pipelined_adder;

  localparam int unsigned ST1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv1, ir1, cin1, sub1, ov1, or1, co1, of1;
  logic [7:0] a1, b1, s1;
  logic       iv2, ir2, cin2, sub2, ov2, or2, co2, of2;
  logic [3:0] a2, b2, s2;

  pipelined_adder #(.WIDTH(8), .CHUNK(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .Cin(cin1), .Sub(sub1), .out_valid(ov1), .out_ready(or1), .S(s1),
    .Cout(co1), .Ovf(of1));

  pipelined_adder #(.WIDTH(4), .CHUNK(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
    .Cin(cin2), .Sub(sub2), .out_valid(ov2), .out_ready(or2), .S(s2),
    .Cout(co2), .Ovf(of2));

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t pend1, pend2;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b,
                                  input logic cin, input logic sub);
    exp_t r;
    logic [3:0] bb;
    logic [4:0] f;
    bb = sub ? ~b : b;
    f = {1'b0, a} + {1'b0, bb} + 5'(sub ? 1'b1 : cin);
    r.s = 8'(f[3:0]);
    r.c = f[4];
    r.o = (a[3] == bb[3]) && (f[3] != a[3]);
    r.due = 0;
    return r;
  endfunction

  // Monitors retire a result whenever the DUT presents one and it is taken.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL m1_unexpected: got S=%0h with no pending transaction", s1);
      end else begin
        e = q1.pop_front();
        chk("m1_S", 32'(s1), 32'(e.s));
        chk("m1_Cout", 32'(co1), 32'(e.c));
        chk("m1_Ovf", 32'(of1), 32'(e.o));
        if (e.due != 0) chk("m1_latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL m2_unexpected: got S=%0h with no pending transaction", s2);
      end else begin
        e = q2.pop_front();
        chk("m2_S", 32'(s2), 32'(e.s));
        chk("m2_Cout", 32'(co2), 32'(e.c));
        chk("m2_Ovf", 32'(of2), 32'(e.o));
      end
    end
  end

  // Random consumer for the sweep instance.
  always @(posedge clk) begin
    #1;
    or2 = 1'($urandom_range(0, 1));
  end

  task automatic set1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [7:0] es, input logic ec,
                      input logic eo, input int lat);
    iv1 = 1'b1; a1 = a; b1 = b; cin1 = cin; sub1 = sub;
    pend1 = '{s: es, c: ec, o: eo, due: lat};
  endtask

  // One clock: sample acceptance before the edge, queue expectations after it.
  task automatic step(output bit acc1, output bit acc2);
    exp_t p;
    #2;
    acc1 = iv1 && ir1;
    acc2 = iv2 && ir2;
    @(posedge clk);
    #1;
    if (acc1) begin
      p = pend1;
      if (p.due != 0) p.due = cyc + ST1 - 1;
      q1.push_back(p);
    end
    if (acc2) q2.push_back(pend2);
  endtask

  task automatic steps(input int n);
    bit x1, x2;
    for (int i = 0; i < n; i++) step(x1, x2);
  endtask

  initial begin
    bit acc1, acc2;
    int tries;
    rst = 1'b1;
    iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; or1 = 1'b1;
    iv2 = 0; a2 = '0; b2 = '0; cin2 = 0; sub2 = 0; or2 = 1'b1;
    pend1 = '{s: 8'h00, c: 1'b0, o: 1'b0, due: 0};
    pend2 = pend1;
    #12 rst = 1'b0;
    chk("rst_out_valid", 32'(ov1), 0);
    chk("rst_S", 32'(s1), 0);
    chk("rst_Cout", 32'(co1), 0);
    chk("rst_Ovf", 32'(of1), 0);
    chk("rst_in_ready", 32'(ir1), 1);
    chk("rst2_out_valid", 32'(ov2), 0);
    chk("rst2_S", 32'(s2), 0);
    @(posedge clk);
    #1;

    // Add/subtract corner cases.
    set1(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 1); step(acc1, acc2);
    set1(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1); step(acc1, acc2);
    set1(8'h05, 8'h07, 1, 1, 8'hFE, 0, 0, 1); step(acc1, acc2);
    set1(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 1); step(acc1, acc2);
    set1(8'h3C, 8'h0C, 1, 0, 8'h49, 0, 0, 1); step(acc1, acc2);
    iv1 = 0; steps(3);

    // Back-to-back stream, in_ready held high.
    set1(8'h10, 8'h01, 0, 0, 8'h11, 0, 0, 1); #1 chk("stream_in_ready0", 32'(ir1), 1); step(acc1, acc2);
    set1(8'h20, 8'h02, 0, 0, 8'h22, 0, 0, 1); #1 chk("stream_in_ready1", 32'(ir1), 1); step(acc1, acc2);
    set1(8'h30, 8'h03, 0, 0, 8'h33, 0, 0, 1); #1 chk("stream_in_ready2", 32'(ir1), 1); step(acc1, acc2);
    iv1 = 0; steps(3);

    // Backpressure: first result held while a third input waits.
    set1(8'h10, 8'h01, 0, 0, 8'h11, 0, 0, 0); step(acc1, acc2);
    set1(8'h20, 8'h02, 0, 0, 8'h22, 0, 0, 0); step(acc1, acc2);
    set1(8'h30, 8'h03, 0, 0, 8'h33, 0, 0, 0);
    or1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_in_ready", 32'(ir1), 0);
      chk("hold_out_valid", 32'(ov1), 1);
      chk("hold_S", 32'(s1), 32'h11);
      step(acc1, acc2);
    end
    or1 = 1'b1;
    step(acc1, acc2);
    chk("bp_third_accepted", 32'(acc1), 1);
    iv1 = 0; steps(4);

    // Reset with two transactions in flight.
    set1(8'h01, 8'h01, 0, 0, 8'h02, 0, 0, 1); step(acc1, acc2);
    set1(8'h02, 8'h02, 0, 0, 8'h04, 0, 0, 1); step(acc1, acc2);
    iv1 = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ov1), 0);
    chk("midrst_S", 32'(s1), 0);
    chk("midrst_Cout", 32'(co1), 0);
    chk("midrst_Ovf", 32'(of1), 0);
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("postrst_in_ready", 32'(ir1), 1);
    set1(8'h40, 8'h02, 0, 0, 8'h42, 0, 0, 1); step(acc1, acc2);
    iv1 = 0; steps(4);
    chk("q1_drained", q1.size(), 0);

    // Exhaustive 4-bit sweep with a random consumer.
    for (int sb = 0; sb < 2; sb++)
      for (int cn = 0; cn < 2; cn++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            iv2 = 1'b1; a2 = 4'(a); b2 = 4'(b); cin2 = 1'(cn); sub2 = 1'(sb);
            pend2 = model4(4'(a), 4'(b), 1'(cn), 1'(sb));
            tries = 0;
            do begin
              step(acc1, acc2);
              tries++;
            end while (!acc2 && tries < 100);
            if (!acc2) begin
              checks++; errors++;
              $display("FAIL sweep_accept: not accepted after %0d cycles", tries);
            end
          end
    iv2 = 0;
    tries = 0;
    while (q2.size() != 0 && tries < 300) begin
      step(acc1, acc2);
      tries++;
    end
    chk("q2_drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
